// File: rtl/core_external_irq_collector.sv
// ---------------------------------------------------------------------------
// core_external_irq_collector
//
// Collects 64 external interrupt lines into a pending set and presents the
// lowest-numbered enabled pending line to core_interrupt_manager, one request
// at a time. A presented request stays frozen until the manager acks it.
//
// Ports
//   iCLOCK           core clock, all logic on posedge
//   iRESET_SYNC      synchronous reset, active-high
//   iIRQ_LINE        raw IRQ lines, already synchronous to iCLOCK
//   iIRQ_EDGE_MODE   per line: 1 = rising-edge latched, 0 = level
//   iIRQ_ENABLE      per line: 1 = eligible for selection
//   iPEND_CLR_VALID  software clear of one pending edge bit
//   iPEND_CLR_NUM    line to clear
//   oPENDING         registered pending set (edge bits OR level bits)
//   oEXT_ACTIVE      request presented to the interrupt manager
//   oEXT_NUM         presented line number
//   iEXT_ACK         manager accepted the presented request
// ---------------------------------------------------------------------------
module core_external_irq_collector (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic [63:0] iIRQ_LINE,
  input  logic [63:0] iIRQ_EDGE_MODE,
  input  logic [63:0] iIRQ_ENABLE,
  input  logic        iPEND_CLR_VALID,
  input  logic [5:0]  iPEND_CLR_NUM,
  output logic [63:0] oPENDING,
  output logic        oEXT_ACTIVE,
  output logic [5:0]  oEXT_NUM,
  input  logic        iEXT_ACK
);

  // Fixed at 64 because the line number is 6 bits wide.
  localparam int unsigned P_IRQ_N = 64;
  localparam int unsigned NumW    = 6;

  typedef enum logic [0:0] {
    StIdle,
    StPresent
  } stateE;

  stateE             stateQ;
  logic              extActiveQ;
  logic [NumW-1:0]   extNumQ;

  logic [P_IRQ_N-1:0] lineHistQ;
  logic [P_IRQ_N-1:0] edgeModeQ;
  logic [P_IRQ_N-1:0] edgePendQ;
  logic [P_IRQ_N-1:0] edgePendD;
  logic [P_IRQ_N-1:0] pendingQ;
  logic [P_IRQ_N-1:0] pendingD;

  logic [P_IRQ_N-1:0] riseMask;
  logic [P_IRQ_N-1:0] ackMask;
  logic [P_IRQ_N-1:0] swClrMask;
  logic [P_IRQ_N-1:0] modeChgMask;
  logic [P_IRQ_N-1:0] clrMask;

  logic [P_IRQ_N-1:0] cand;
  logic               candAny;
  logic [NumW-1:0]    winner;
  logic               ackTaken;

  // -------------------------------------------------------------------------
  // Pending-set next state
  // -------------------------------------------------------------------------
  assign ackTaken = (stateQ == StPresent) && iEXT_ACK;

  always_comb begin
    ackMask   = '0;
    swClrMask = '0;
    for (int unsigned i = 0; i < P_IRQ_N; i++) begin
      if (ackTaken && (extNumQ == NumW'(i))) begin
        ackMask[i] = 1'b1;
      end
      if (iPEND_CLR_VALID && (iPEND_CLR_NUM == NumW'(i))) begin
        swClrMask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    riseMask    = iIRQ_LINE & ~lineHistQ;
    modeChgMask = iIRQ_EDGE_MODE ^ edgeModeQ;
    clrMask     = ackMask | swClrMask | modeChgMask;
    // A rise in the same cycle as any clear still sets the bit, so no new
    // event is lost. Level-mode lines never hold an edge bit.
    edgePendD   = ((edgePendQ & ~clrMask) | riseMask) & iIRQ_EDGE_MODE;
    pendingD    = edgePendD | (iIRQ_LINE & ~iIRQ_EDGE_MODE);
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      // History of all ones: lines already high out of reset make no edge.
      lineHistQ <= '1;
      edgeModeQ <= '0;
      edgePendQ <= '0;
      pendingQ  <= '0;
    end else begin
      lineHistQ <= iIRQ_LINE;
      edgeModeQ <= iIRQ_EDGE_MODE;
      edgePendQ <= edgePendD;
      pendingQ  <= pendingD;
    end
  end

  // -------------------------------------------------------------------------
  // Selection: lowest-index enabled pending line, from registered state.
  // Masked lines stay pending and become eligible once enabled.
  // -------------------------------------------------------------------------
  always_comb begin
    cand    = pendingQ & iIRQ_ENABLE;
    candAny = |cand;
    winner  = '0;
    // Descending scan so the last hit (lowest index) wins.
    for (int i = P_IRQ_N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        winner = NumW'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Presentation FSM with registered outputs.
  // Returning to StIdle on ack guarantees at least one idle (bubble) cycle
  // before the next request is presented.
  // -------------------------------------------------------------------------
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      stateQ     <= StIdle;
      extActiveQ <= 1'b0;
      extNumQ    <= '0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          // Acks arriving while idle are ignored.
          if (candAny) begin
            stateQ     <= StPresent;
            extActiveQ <= 1'b1;
            extNumQ    <= winner;
          end
        end
        StPresent: begin
          // Line drop, disable or clear never withdraw a presented request.
          if (iEXT_ACK) begin
            stateQ     <= StIdle;
            extActiveQ <= 1'b0;
          end
        end
        default: begin
          stateQ     <= StIdle;
          extActiveQ <= 1'b0;
        end
      endcase
    end
  end

  assign oPENDING    = pendingQ;
  assign oEXT_ACTIVE = extActiveQ;
  assign oEXT_NUM    = extNumQ;

endmodule

// File: tb/tb_core_external_irq_collector.sv
module tb_core_external_irq_collector;

  logic        iCLOCK;
  logic        iRESET_SYNC;
  logic [63:0] iIRQ_LINE;
  logic [63:0] iIRQ_EDGE_MODE;
  logic [63:0] iIRQ_ENABLE;
  logic        iPEND_CLR_VALID;
  logic [5:0]  iPEND_CLR_NUM;
  logic [63:0] oPENDING;
  logic        oEXT_ACTIVE;
  logic [5:0]  oEXT_NUM;
  logic        iEXT_ACK;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [63:0] mEdge;
  logic [63:0] mPrevLine;
  logic [63:0] mPrevMode;
  logic [63:0] mPend;
  logic        mActive;
  logic [5:0]  mNum;

  core_external_irq_collector dut (
    .iCLOCK          (iCLOCK),
    .iRESET_SYNC     (iRESET_SYNC),
    .iIRQ_LINE       (iIRQ_LINE),
    .iIRQ_EDGE_MODE  (iIRQ_EDGE_MODE),
    .iIRQ_ENABLE     (iIRQ_ENABLE),
    .iPEND_CLR_VALID (iPEND_CLR_VALID),
    .iPEND_CLR_NUM   (iPEND_CLR_NUM),
    .oPENDING        (oPENDING),
    .oEXT_ACTIVE     (oEXT_ACTIVE),
    .oEXT_NUM        (oEXT_NUM),
    .iEXT_ACK        (iEXT_ACK)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  // One clock: compute the model's next state from the current inputs,
  // advance the clock, commit, then settle 1 time unit past the edge.
  task automatic tick();
    logic [63:0] nEdge, nPend;
    logic        nAct;
    logic [5:0]  nNum;
    bit          found, rise, clr, chg;
    nEdge = mEdge; nPend = mPend; nAct = mActive; nNum = mNum;
    if (iRESET_SYNC) begin
      nEdge = '0; nPend = '0; nAct = 1'b0; nNum = '0;
    end else begin
      for (int k = 0; k < 64; k++) begin
        rise = iIRQ_LINE[k] && !mPrevLine[k];
        clr  = (mActive && iEXT_ACK && (mNum == 6'(k))) ||
               (iPEND_CLR_VALID && (iPEND_CLR_NUM == 6'(k)));
        chg  = iIRQ_EDGE_MODE[k] != mPrevMode[k];
        if (!iIRQ_EDGE_MODE[k])  nEdge[k] = 1'b0;
        else if (rise)           nEdge[k] = 1'b1;
        else if (clr || chg)     nEdge[k] = 1'b0;
        else                     nEdge[k] = mEdge[k];
        nPend[k] = iIRQ_EDGE_MODE[k] ? nEdge[k] : iIRQ_LINE[k];
      end
      if (mActive) begin
        if (iEXT_ACK) nAct = 1'b0;
      end else begin
        found = 1'b0;
        for (int k = 0; k < 64; k++) begin
          if (!found && mPend[k] && iIRQ_ENABLE[k]) begin
            found = 1'b1; nAct = 1'b1; nNum = 6'(k);
          end
        end
      end
    end
    @(posedge iCLOCK);
    mPrevLine = iRESET_SYNC ? '1 : iIRQ_LINE;
    mPrevMode = iRESET_SYNC ? '0 : iIRQ_EDGE_MODE;
    mEdge = nEdge; mPend = nPend; mActive = nAct; mNum = nNum;
    #1;
  endtask

  task automatic test_reset();
    iIRQ_LINE = 64'd0;
    iIRQ_LINE[5] = 1'b1;
    iRESET_SYNC = 1'b1;
    tick();
    tick();
    checks++;
    if (oPENDING !== 64'd0 || oEXT_ACTIVE !== 1'b0 || oEXT_NUM !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: pending=%h active=%b num=%0d, required 0/0/0",
               oPENDING, oEXT_ACTIVE, oEXT_NUM);
    end
    iRESET_SYNC = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (oPENDING !== 64'd0 || oEXT_ACTIVE !== 1'b0) begin
        errors++;
        $display("FAIL reset_high_line cyc%0d: pending=%h active=%b, required 0/0",
                 c, oPENDING, oEXT_ACTIVE);
      end
    end
    iIRQ_LINE[5] = 1'b0;
    tick();
  endtask

  task automatic test_single_edge();
    iIRQ_LINE[3] = 1'b1;
    tick();
    checks++;
    if (oPENDING !== 64'h8 || oEXT_ACTIVE !== 1'b0) begin
      errors++;
      $display("FAIL edge_pend: pending=%h active=%b, required 8/0", oPENDING, oEXT_ACTIVE);
    end
    tick();
    checks++;
    if (oEXT_ACTIVE !== 1'b1 || oEXT_NUM !== 6'd3) begin
      errors++;
      $display("FAIL edge_present: active=%b num=%0d, required 1/3", oEXT_ACTIVE, oEXT_NUM);
    end
    tick();
    tick();
    iEXT_ACK = 1'b1;
    tick();
    iEXT_ACK = 1'b0;
    checks++;
    if (oEXT_ACTIVE !== 1'b0 || oPENDING !== 64'd0) begin
      errors++;
      $display("FAIL edge_ack: active=%b pending=%h, required 0/0", oEXT_ACTIVE, oPENDING);
    end
    tick();
    checks++;
    if (oEXT_ACTIVE !== 1'b0) begin
      errors++;
      $display("FAIL edge_no_repeat: active=%b, required 0", oEXT_ACTIVE);
    end
    iIRQ_LINE[3] = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    iIRQ_LINE[7] = 1'b1;
    iIRQ_LINE[40] = 1'b1;
    tick();
    tick();
    checks++;
    if (oEXT_ACTIVE !== 1'b1 || oEXT_NUM !== 6'd7) begin
      errors++;
      $display("FAIL prio_first: active=%b num=%0d, required 1/7", oEXT_ACTIVE, oEXT_NUM);
    end
    iEXT_ACK = 1'b1;
    tick();
    iEXT_ACK = 1'b0;
    checks++;
    if (oEXT_ACTIVE !== 1'b0 || oPENDING !== (64'd1 << 40)) begin
      errors++;
      $display("FAIL prio_bubble: active=%b pending=%h, required 0/%h",
               oEXT_ACTIVE, oPENDING, 64'd1 << 40);
    end
    tick();
    checks++;
    if (oEXT_ACTIVE !== 1'b1 || oEXT_NUM !== 6'd40) begin
      errors++;
      $display("FAIL prio_second: active=%b num=%0d, required 1/40", oEXT_ACTIVE, oEXT_NUM);
    end
    iEXT_ACK = 1'b1;
    tick();
    iEXT_ACK = 1'b0;
    tick();
    checks++;
    if (oEXT_ACTIVE !== 1'b0 || oPENDING !== 64'd0) begin
      errors++;
      $display("FAIL prio_idle: active=%b pending=%h, required 0/0", oEXT_ACTIVE, oPENDING);
    end
    iIRQ_LINE[7] = 1'b0;
    iIRQ_LINE[40] = 1'b0;
    tick();
  endtask

  task automatic test_level_reack();
    iIRQ_EDGE_MODE[9] = 1'b0;
    iIRQ_LINE[9] = 1'b1;
    tick();
    tick();
    checks++;
    if (oEXT_ACTIVE !== 1'b1 || oEXT_NUM !== 6'd9) begin
      errors++;
      $display("FAIL level_present: active=%b num=%0d, required 1/9", oEXT_ACTIVE, oEXT_NUM);
    end
    iEXT_ACK = 1'b1;
    tick();
    iEXT_ACK = 1'b0;
    checks++;
    if (oEXT_ACTIVE !== 1'b0 || oPENDING !== (64'd1 << 9)) begin
      errors++;
      $display("FAIL level_after_ack: active=%b pending=%h, required 0/%h",
               oEXT_ACTIVE, oPENDING, 64'd1 << 9);
    end
    tick();
    checks++;
    if (oEXT_ACTIVE !== 1'b1 || oEXT_NUM !== 6'd9) begin
      errors++;
      $display("FAIL level_represent: active=%b num=%0d, required 1/9", oEXT_ACTIVE, oEXT_NUM);
    end
    iIRQ_LINE[9] = 1'b0;
    iEXT_ACK = 1'b1;
    tick();
    iEXT_ACK = 1'b0;
    tick();
    tick();
    checks++;
    if (oEXT_ACTIVE !== 1'b0 || oPENDING !== 64'd0) begin
      errors++;
      $display("FAIL level_drop: active=%b pending=%h, required 0/0", oEXT_ACTIVE, oPENDING);
    end
    iIRQ_EDGE_MODE[9] = 1'b1;
    tick();
  endtask

  task automatic test_masked_and_clear();
    iIRQ_ENABLE[12] = 1'b0;
    iIRQ_ENABLE[13] = 1'b0;
    iIRQ_LINE[12] = 1'b1;
    iIRQ_LINE[13] = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (oEXT_ACTIVE !== 1'b0 || oPENDING !== 64'h3000) begin
      errors++;
      $display("FAIL masked_hold: active=%b pending=%h, required 0/3000", oEXT_ACTIVE, oPENDING);
    end
    iPEND_CLR_VALID = 1'b1;
    iPEND_CLR_NUM = 6'd13;
    iIRQ_ENABLE[12] = 1'b1;
    tick();
    iPEND_CLR_VALID = 1'b0;
    checks++;
    if (oEXT_ACTIVE !== 1'b1 || oEXT_NUM !== 6'd12 || oPENDING !== 64'h1000) begin
      errors++;
      $display("FAIL masked_enable: active=%b num=%0d pending=%h, required 1/12/1000",
               oEXT_ACTIVE, oEXT_NUM, oPENDING);
    end
    iEXT_ACK = 1'b1;
    tick();
    iEXT_ACK = 1'b0;
    iIRQ_LINE[12] = 1'b0;
    iIRQ_LINE[13] = 1'b0;
    iIRQ_ENABLE[13] = 1'b1;
    tick();
    checks++;
    if (oEXT_ACTIVE !== 1'b0 || oPENDING !== 64'd0) begin
      errors++;
      $display("FAIL masked_done: active=%b pending=%h, required 0/0", oEXT_ACTIVE, oPENDING);
    end
  endtask

  task automatic test_ack_collision_and_reset();
    iIRQ_LINE[2] = 1'b1;
    tick();
    tick();
    iIRQ_LINE[2] = 1'b0;
    tick();
    checks++;
    if (oEXT_ACTIVE !== 1'b1 || oEXT_NUM !== 6'd2) begin
      errors++;
      $display("FAIL coll_present: active=%b num=%0d, required 1/2", oEXT_ACTIVE, oEXT_NUM);
    end
    iIRQ_LINE[2] = 1'b1;
    iEXT_ACK = 1'b1;
    tick();
    iEXT_ACK = 1'b0;
    checks++;
    if (oEXT_ACTIVE !== 1'b0 || oPENDING !== 64'h4) begin
      errors++;
      $display("FAIL coll_set_wins: active=%b pending=%h, required 0/4", oEXT_ACTIVE, oPENDING);
    end
    tick();
    checks++;
    if (oEXT_ACTIVE !== 1'b1 || oEXT_NUM !== 6'd2) begin
      errors++;
      $display("FAIL coll_represent: active=%b num=%0d, required 1/2", oEXT_ACTIVE, oEXT_NUM);
    end
    iRESET_SYNC = 1'b1;
    tick();
    iRESET_SYNC = 1'b0;
    checks++;
    if (oEXT_ACTIVE !== 1'b0 || oPENDING !== 64'd0 || oEXT_NUM !== 6'd0) begin
      errors++;
      $display("FAIL reset_in_present: active=%b pending=%h num=%0d, required 0/0/0",
               oEXT_ACTIVE, oPENDING, oEXT_NUM);
    end
    tick();
    checks++;
    if (oEXT_ACTIVE !== 1'b0 || oPENDING !== 64'd0) begin
      errors++;
      $display("FAIL reset_no_edge: active=%b pending=%h, required 0/0", oEXT_ACTIVE, oPENDING);
    end
    iIRQ_LINE[2] = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int b;
    for (int c = 0; c < 3000; c++) begin
      iRESET_SYNC = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 64; k++) begin
        if ($urandom_range(0, 23) == 0) iIRQ_LINE[k] = ~iIRQ_LINE[k];
      end
      if ($urandom_range(0, 15) == 0) begin
        b = $urandom_range(0, 63);
        iIRQ_EDGE_MODE[b] = ~iIRQ_EDGE_MODE[b];
      end
      if ($urandom_range(0, 7) == 0) begin
        b = $urandom_range(0, 63);
        iIRQ_ENABLE[b] = ~iIRQ_ENABLE[b];
      end
      iPEND_CLR_VALID = ($urandom_range(0, 5) == 0);
      iPEND_CLR_NUM = 6'($urandom_range(0, 63));
      iEXT_ACK = mActive ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (oPENDING !== mPend || oEXT_ACTIVE !== mActive || oEXT_NUM !== mNum) begin
        errors++;
        $display("FAIL random cyc%0d: pending=%h active=%b num=%0d, required %h/%b/%0d",
                 c, oPENDING, oEXT_ACTIVE, oEXT_NUM, mPend, mActive, mNum);
      end
    end
    iRESET_SYNC = 1'b0;
    iPEND_CLR_VALID = 1'b0;
    iEXT_ACK = 1'b0;
  endtask

  initial begin
    iRESET_SYNC = 1'b1;
    iIRQ_LINE = '0;
    iIRQ_EDGE_MODE = '1;
    iIRQ_ENABLE = '1;
    iPEND_CLR_VALID = 1'b0;
    iPEND_CLR_NUM = '0;
    iEXT_ACK = 1'b0;
    mEdge = '0; mPrevLine = '1; mPrevMode = '0; mPend = '0; mActive = 1'b0; mNum = '0;
    test_reset();
    test_single_edge();
    test_priority();
    test_level_reack();
    test_masked_and_clear();
    test_ack_collision_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
